// File: rtl/ellipse_pkg.sv
// Shared definitions for the shape program sequencer: register IDs, the
// 89-bit shape descriptor layout, FSM encoding and the beat field selector.
package ellipse_pkg;

    localparam logic [2:0] REG_X     = 3'd0;
    localparam logic [2:0] REG_Y     = 3'd1;
    localparam logic [2:0] REG_W     = 3'd2;
    localparam logic [2:0] REG_H     = 3'd3;
    localparam logic [2:0] REG_COLOR = 3'd4;

    localparam int DESC_W = 89;

    typedef struct packed {
        logic [10:0] stage;
        logic [10:0] x_coord;
        logic [11:0] y_coord;
        logic [10:0] width;
        logic [11:0] height;
        logic [31:0] color;
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Zero-extended descriptor field carried by a given register-write beat.
    function automatic logic [31:0] beat_field(input desc_t d, input logic [2:0] beat);
        logic [31:0] f;
        case (beat)
            REG_X:     f = {21'd0, d.x_coord};
            REG_Y:     f = {20'd0, d.y_coord};
            REG_W:     f = {21'd0, d.width};
            REG_H:     f = {20'd0, d.height};
            REG_COLOR: f = d.color;
            default:   f = 32'd0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; pushes while full and pops
// while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array and read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

endmodule

// File: rtl/shape_program_sequencer.sv
// Head-of-chain controller: buffers host shape descriptors and, during blanking,
// serialises each into five register-write beats; otherwise passes pixels through.
module shape_program_sequencer
    import ellipse_pkg::*;
#(
    parameter int NUM_STAGES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_stage,
    input  logic [10:0] cmd_x_coord,
    input  logic [11:0] cmd_y_coord,
    input  logic [10:0] cmd_width,
    input  logic [11:0] cmd_height,
    input  logic [31:0] cmd_color,
    input  logic        frame_blank,
    input  logic [10:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic [31:0] pix_data,
    output logic        pix_ready,
    output logic        program_out,
    output logic [10:0] x_out,
    output logic [11:0] y_out,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        err_stage
);

    localparam logic [10:0] STAGE_LIMIT = 11'(NUM_STAGES);
    localparam logic [2:0]  LAST_BEAT   = REG_COLOR;

    state_t              state_r;
    state_t              state_n;
    logic [2:0]          beat_r;
    logic [2:0]          beat_n;
    desc_t               desc_r;
    desc_t               cmd_desc_s;
    logic [DESC_W-1:0]   fifo_dout_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                pop_s;
    logic                stage_bad_s;

    assign cmd_desc_s  = '{stage: cmd_stage, x_coord: cmd_x_coord, y_coord: cmd_y_coord,
                           width: cmd_width, height: cmd_height, color: cmd_color};
    assign cmd_ready   = !fifo_full_s;
    assign busy        = !fifo_empty_s || (state_r != ST_IDLE);
    assign pix_ready   = (state_r != ST_WRITE);
    assign stage_bad_s = (desc_r.stage >= STAGE_LIMIT);

    sync_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop_s),
        .din   (cmd_desc_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // FSM state, beat counter and the descriptor being serialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            beat_r  <= 3'd0;
            desc_r  <= '0;
        end else begin
            state_r <= state_n;
            beat_r  <= beat_n;
            if (pop_s) begin
                desc_r <= desc_t'(fifo_dout_s);
            end else begin
                desc_r <= desc_r;
            end
        end
    end

    // Next-state logic; a descriptor only starts in blanking but never stops early.
    always_comb begin
        state_n = state_r;
        beat_n  = beat_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && frame_blank) begin
                    pop_s   = 1'b1;
                    state_n = ST_CHECK;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CHECK: begin
                beat_n = 3'd0;
                if (stage_bad_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (beat_r == LAST_BEAT) begin
                    state_n = ST_IDLE;
                    beat_n  = 3'd0;
                end else begin
                    beat_n  = beat_r + 3'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                beat_n  = 3'd0;
            end
        endcase
    end

    // Output slot: a program beat while writing, otherwise the delayed pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            program_out <= 1'b0;
            x_out       <= 11'd0;
            y_out       <= 12'd0;
            data_out    <= 32'd0;
            err_stage   <= 1'b0;
        end else begin
            err_stage <= (state_r == ST_CHECK) && stage_bad_s;
            if (state_r == ST_WRITE) begin
                program_out <= 1'b1;
                x_out       <= desc_r.stage;
                y_out       <= {9'd0, beat_r};
                data_out    <= beat_field(desc_r, beat_r);
            end else begin
                program_out <= 1'b0;
                x_out       <= pix_x;
                y_out       <= pix_y;
                data_out    <= pix_data;
            end
        end
    end

endmodule
